// File: rtl/scan_dff_bank.sv
// WIDTH-bit register bank with clock enable, synchronous set and a serial scan path.
// A frame counter pulses scan_done on the edge that completes every WIDTH-th consecutive shift.
module scan_dff_bank #(
    parameter int                 WIDTH       = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0]   SET_VALUE   = {WIDTH{1'b1}},
    localparam int                CW          = $clog2(WIDTH+1)
) (
    input  logic             clk,
    input  logic             resetb,
    input  logic             set,
    input  logic             en,
    input  logic [WIDTH-1:0] D,
    input  logic             scan_en,
    input  logic             scan_in,
    output logic [WIDTH-1:0] Q,
    output logic             scan_out,
    output logic             scan_done,
    output logic [CW-1:0]    shift_cnt
);

    typedef enum logic {IDLE, SHIFT} state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state, state_n;
    logic [WIDTH-1:0] q_shift, q_n;
    logic [CW-1:0]    cnt_n, cnt_base;
    logic             done_n;

    // Serial data enters at bit 0; a 1-bit bank simply takes scan_in.
    if (WIDTH == 1) begin : g_w1
        assign q_shift = scan_in;
    end else begin : g_wn
        assign q_shift = {Q[WIDTH-2:0], scan_in};
    end

    assign scan_out = Q[WIDTH-1];

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state     <= IDLE;
            Q         <= RESET_VALUE;
            shift_cnt <= '0;
            scan_done <= 1'b0;
        end else begin
            state     <= state_n;
            Q         <= q_n;
            shift_cnt <= cnt_n;
            scan_done <= done_n;
        end
    end

    always_comb begin
        state_n  = IDLE;
        q_n      = Q;
        cnt_n    = '0;
        done_n   = 1'b0;
        // A frame only continues counting from a shift edge; otherwise it starts over.
        cnt_base = (state == SHIFT) ? shift_cnt : '0;

        if (set) begin
            q_n = SET_VALUE;
        end else if (scan_en) begin
            state_n = SHIFT;
            q_n     = q_shift;
            if (cnt_base == LAST) begin
                cnt_n  = '0;
                done_n = 1'b1;
            end else begin
                cnt_n  = cnt_base + 1'b1;
            end
        end else if (en) begin
            q_n = D;
        end
    end

endmodule

// File: tb/tb_scan_dff_bank.sv
// Directed bench for scan_dff_bank at WIDTH=4: load, hold, scan frames, abort, set priority, async reset.
`timescale 1ns/100ps
module tb_scan_dff_bank;

    localparam int W = 4;

    logic         clk, resetb, set, en, scan_en, scan_in;
    logic [W-1:0] D, Q;
    logic         scan_out, scan_done;
    logic [2:0]   shift_cnt;

    int checks = 0;
    int errors = 0;

    scan_dff_bank #(.WIDTH(W), .RESET_VALUE(4'h0), .SET_VALUE(4'hF)) dut (
        .clk(clk), .resetb(resetb), .set(set), .en(en), .D(D),
        .scan_en(scan_en), .scan_in(scan_in), .Q(Q), .scan_out(scan_out),
        .scan_done(scan_done), .shift_cnt(shift_cnt)
    );

    initial clk = 1'b0;
    always #1 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Advance one active edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #0.5;
    endtask

    initial begin
        logic [3:0] sbits;
        resetb = 1'b0; set = 1'b0; en = 1'b1; D = 4'hA; scan_en = 1'b0; scan_in = 1'b0;

        // 1: reset then first load
        step(); step();
        chk("rst_q", 32'(Q), 32'h0);
        chk("rst_so", 32'(scan_out), 32'h0);
        chk("rst_done", 32'(scan_done), 32'h0);
        chk("rst_cnt", 32'(shift_cnt), 32'h0);
        resetb = 1'b1;
        step();
        chk("load_a", 32'(Q), 32'hA);

        // 2: hold with en low, then reload
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            D = (i % 2 == 0) ? 4'h5 : 4'h3;
            step();
            chk("hold", 32'(Q), 32'hA);
        end
        en = 1'b1; D = 4'h3;
        step();
        chk("load_3", 32'(Q), 32'h3);
        D = 4'hA;
        step();
        chk("load_a2", 32'(Q), 32'hA);
        en = 1'b0;

        // 3: one frame 1,0,1,1 from 4'hA
        sbits = 4'b1101;  // scan_in order: bit0 first
        scan_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            scan_in = sbits[i];
            chk("so_pre", 32'(scan_out), (i % 2 == 0) ? 32'h1 : 32'h0);
            step();
            chk("f_cnt", 32'(shift_cnt), 32'((i + 1) % 4));
            chk("f_done", 32'(scan_done), (i == 3) ? 32'h1 : 32'h0);
        end
        chk("f_q", 32'(Q), 32'hB);
        scan_en = 1'b0;
        step();
        chk("f_done_clr", 32'(scan_done), 32'h0);
        chk("f_q_hold", 32'(Q), 32'hB);

        // 4: continuous scan wraps with no dead cycle
        scan_en = 1'b1; scan_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("c_cnt", 32'(shift_cnt), 32'((i + 1) % 4));
            chk("c_done", 32'(scan_done), (i % 4 == 3) ? 32'h1 : 32'h0);
        end
        scan_en = 1'b0;
        step();
        chk("c_q", 32'(Q), 32'h0);

        // 5: abort mid-frame, then set overrides everything
        en = 1'b1; D = 4'h6;
        step();
        en = 1'b0;
        scan_en = 1'b1; scan_in = 1'b1;
        step();
        chk("a_cnt1", 32'(shift_cnt), 32'h1);
        step();
        chk("a_cnt2", 32'(shift_cnt), 32'h2);
        scan_en = 1'b0;
        step();
        chk("a_cnt0", 32'(shift_cnt), 32'h0);
        chk("a_done", 32'(scan_done), 32'h0);
        chk("a_q", 32'(Q), 32'hB);
        set = 1'b1; scan_en = 1'b1; en = 1'b1; D = 4'h0;
        step();
        chk("s_q", 32'(Q), 32'hF);
        chk("s_cnt", 32'(shift_cnt), 32'h0);
        chk("s_done", 32'(scan_done), 32'h0);
        // scan beats parallel load
        set = 1'b0; scan_in = 1'b0;
        step();
        chk("se_q", 32'(Q), 32'hE);
        chk("se_cnt", 32'(shift_cnt), 32'h1);
        scan_en = 1'b0; en = 1'b0;
        step();

        // 6: async reset between edges during a scan
        scan_en = 1'b1; scan_in = 1'b1;
        step(); step();
        chk("r_cnt2", 32'(shift_cnt), 32'h2);
        chk("r_q", 32'(Q), 32'hB);
        #0.3 resetb = 1'b0;
        #0.2;
        chk("ar_q", 32'(Q), 32'h0);
        chk("ar_cnt", 32'(shift_cnt), 32'h0);
        chk("ar_so", 32'(scan_out), 32'h0);
        #0.2 resetb = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rr_cnt", 32'(shift_cnt), 32'((i + 1) % 4));
            chk("rr_done", 32'(scan_done), (i == 3) ? 32'h1 : 32'h0);
        end
        chk("rr_q", 32'(Q), 32'hF);
        scan_en = 1'b0;
        step();
        chk("rr_clr", 32'(scan_done), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/scan_dff_bank.md
Name: scan_dff_bank

Overview:
- Parametrised successor to the single static D flip-flop: a WIDTH-bit register bank with clock enable, synchronous set, and a built-in serial scan path.
- Scan mode shifts one bit per cycle through the bank. A shift counter pulses scan_done each time a full WIDTH-bit frame has been loaded.
- Used as the building block for configuration/scan chains in generated fabrics. Multiple banks daisy-chain scan_out to scan_in.

Parameters:
- WIDTH, 8, number of flip-flops in the bank (>=1).
- RESET_VALUE, {WIDTH{1'b0}}, value of Q while resetb is low.
- SET_VALUE, {WIDTH{1'b1}}, value loaded into Q by synchronous set.

Ports:
- clk  input  1  clock, rising-edge active.
- resetb  input  1  reset, asynchronous, active-low.
- set  input  1  synchronous set, active-high.
- en  input  1  parallel-load enable.
- D  input  WIDTH  parallel data in.
- scan_en  input  1  scan shift enable.
- scan_in  input  1  serial data in (enters at bit 0).
- Q  output  WIDTH  register contents.
- scan_out  output  1  serial data out = Q[WIDTH-1].
- scan_done  output  1  one-cycle pulse: a full WIDTH-bit frame has been shifted.
- shift_cnt  output  $clog2(WIDTH+1)  consecutive shift cycles in the current frame.

Behaviour:
- Reset (resetb=0, asynchronous, immediate, independent of clk):
  - Q=RESET_VALUE, scan_out=RESET_VALUE[WIDTH-1], scan_done=0, shift_cnt=0.
  - Outputs hold these values until the first rising edge after resetb=1.
- Per-edge priority (resetb=1): set > scan_en > en > hold.
  - set=1: Q<=SET_VALUE; shift_cnt<=0; scan_done<=0. Scan and en are ignored.
  - scan_en=1: Q<={Q[WIDTH-2:0],scan_in}. For WIDTH=1, Q<=scan_in. D and en are ignored.
  - en=1 and scan_en=0: Q<=D. Latency is 1 cycle.
  - Otherwise: Q holds.
- scan_out is a direct wire from Q[WIDTH-1]. No extra latency, so banks chain with 1 cycle per bit.
- Counter / done state machine, two states:
  - SHIFT: entered when scan_en=1 and set=0. Edge with shift_cnt<WIDTH-1: shift_cnt<=shift_cnt+1, scan_done<=0. Edge with shift_cnt==WIDTH-1: shift_cnt<=0 (wrap), scan_done<=1.
  - IDLE: scan_en=0 or set=1. shift_cnt<=0, scan_done<=0. This aborts any partial frame; Q keeps the partially shifted contents.
- scan_done rises at the same edge that completes the WIDTH-th shift. It is high while Q holds the full frame and is cleared at the next edge, whatever the inputs.
- Continuous scan_en wraps the counter: scan_done pulses every WIDTH cycles, with no dead cycle between frames.
- WIDTH=1: every scan edge is a complete frame, so scan_done=1 after each shift edge and shift_cnt stays 0.
- en and scan_en both high: scan wins, and the counter behaves as for scan alone.
- resetb asserted mid-frame: counter and done clear immediately. The frame restarts from count 0 after reset is released.
- No X propagation from the counter: shift_cnt never exceeds WIDTH-1.

Test Plan:
All scenarios use WIDTH=4, RESET_VALUE=4'h0, SET_VALUE=4'hF, clk period 2 ns.
1. resetb=0 for 2 cycles, then 1; set=0, en=1, D=4'hA -> during reset Q=0, scan_out=0, scan_done=0, shift_cnt=0; Q=4'hA after the first edge with resetb=1.
2. en=0, D toggled 4'h5/4'h3 for 4 cycles -> Q stays 4'hA. Then en=1, D=4'h3 -> Q=4'h3 after 1 edge.
3. From Q=4'hA: scan_en=1 for 4 edges with scan_in=1,0,1,1 -> Q=4'b1011 (later states elided).
   - scan_out before each edge = 1,0,1,0.
   - shift_cnt=1,2,3,0.
   - scan_done=1 only after the 4th edge; 0 at the next edge.
4. scan_en=1 for 8 consecutive edges -> scan_done pulses after edges 4 and 8 only; shift_cnt sequence 1,2,3,0,1,2,3,0.
5. Abort and set priority:
   - scan_en=1 for 2 edges, then 0 -> shift_cnt=0, no scan_done, Q keeps the 2-bit-shifted value.
   - Then set=1 with scan_en=1, en=1, D=4'h0 -> Q=4'hF, shift_cnt=0, scan_done=0.
6. resetb pulsed low mid-cycle (not on an edge) during a scan with shift_cnt=2 -> Q=0, shift_cnt=0, scan_done=0 immediately, before the next clk edge. After release, a 4-edge scan gives scan_done on the 4th edge.
